// File: rtl/cache_refill_ctrl.sv
// Block refill controller: optional dirty-victim write-back followed by a block read.
// Every memory-side output is driven from a register.
module cache_refill_ctrl #(
  parameter int unsigned c_block_size = 2,
  parameter int unsigned c_line_size  = 32,
  parameter int unsigned address_size = 32,
  parameter int unsigned c_timeout    = 64
) (
  input  logic                                          m_clk_i,
  input  logic                                          m_reset_i,
  input  logic                                          c_miss_i,
  input  logic                                          c_dirty_i,
  input  logic [address_size-c_block_size-3:0]          c_miss_addr_i,
  input  logic [address_size-c_block_size-3:0]          c_victim_addr_i,
  input  logic [(2**c_block_size)*c_line_size-1:0]      c_victim_data_i,
  output logic                                          c_busy_o,
  output logic                                          c_fill_valid_o,
  output logic [(2**c_block_size)*c_line_size-1:0]      c_fill_data_o,
  output logic                                          c_err_o,
  output logic                                          mem_read_o,
  output logic                                          mem_wr_o,
  output logic [address_size-c_block_size-3:0]          mem_addr_o,
  output logic [(2**c_block_size)*c_line_size-1:0]      mem_wr_data_o,
  input  logic                                          mem_busywait_i,
  input  logic                                          mem_read_done_i,
  input  logic                                          mem_write_done_i,
  input  logic [(2**c_block_size)*c_line_size-1:0]      mem_read_data_i
);

  localparam int unsigned BW   = (2 ** c_block_size) * c_line_size;
  localparam int unsigned AW   = address_size - c_block_size - 2;
  localparam int unsigned CntW = ($clog2(c_timeout) >= 8) ? $clog2(c_timeout) + 1 : 8;

  typedef enum logic [2:0] {
    StIdle,
    StWbReq,
    StWbWait,
    StFillReq,
    StFillWait,
    StResp,
    StErr
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [CntW-1:0]   r_wait_cnt;
  logic [CntW-1:0]   w_wait_cnt_d;
  logic              w_timed_out;
  logic              w_accept;

  logic [AW-1:0]     r_miss_addr;
  logic [AW-1:0]     r_victim_addr;
  logic [BW-1:0]     r_victim_data;
  logic              r_dirty;
  logic [AW-1:0]     w_miss_addr_nxt;
  logic [AW-1:0]     w_victim_addr_nxt;
  logic [BW-1:0]     w_victim_data_nxt;
  logic              w_dirty_nxt;

  logic              r_mem_read;
  logic              r_mem_wr;
  logic [AW-1:0]     r_mem_addr;
  logic [BW-1:0]     r_mem_wr_data;
  logic              w_mem_read_d;
  logic              w_mem_wr_d;
  logic [AW-1:0]     w_mem_addr_d;
  logic [BW-1:0]     w_mem_wr_data_d;

  logic [BW-1:0]     r_fill_data;
  logic              r_err;

  assign w_accept    = (r_state == StIdle) && c_miss_i;
  assign w_timed_out = (r_wait_cnt == CntW'(c_timeout - 1));

  // Request fields as they will be after this edge; lets the registered memory
  // outputs line up with the state they belong to.
  assign w_miss_addr_nxt   = w_accept ? c_miss_addr_i   : r_miss_addr;
  assign w_victim_addr_nxt = w_accept ? c_victim_addr_i : r_victim_addr;
  assign w_victim_data_nxt = w_accept ? c_victim_data_i : r_victim_data;
  assign w_dirty_nxt       = w_accept ? c_dirty_i       : r_dirty;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (c_miss_i) w_state_d = c_dirty_i ? StWbReq : StFillReq;
      end
      StWbReq: begin
        if (mem_busywait_i)   w_state_d = StWbWait;
        else if (w_timed_out) w_state_d = StErr;
      end
      StWbWait: begin
        if (mem_write_done_i) w_state_d = StFillReq;
        else if (w_timed_out) w_state_d = StErr;
      end
      StFillReq: begin
        if (mem_busywait_i)   w_state_d = StFillWait;
        else if (w_timed_out) w_state_d = StErr;
      end
      StFillWait: begin
        if (mem_read_done_i)  w_state_d = StResp;
        else if (w_timed_out) w_state_d = StErr;
      end
      StResp:  w_state_d = StIdle;
      StErr:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_wait_cnt_d = '0;
    if (w_state_d == r_state) begin
      unique case (r_state)
        StWbReq, StWbWait, StFillReq, StFillWait: w_wait_cnt_d = r_wait_cnt + CntW'(1);
        default:                                  w_wait_cnt_d = '0;
      endcase
    end
  end

  always_comb begin
    w_mem_read_d    = 1'b0;
    w_mem_wr_d      = 1'b0;
    w_mem_addr_d    = '0;
    w_mem_wr_data_d = '0;
    unique case (w_state_d)
      StWbReq: begin
        w_mem_wr_d      = w_dirty_nxt;
        w_mem_addr_d    = w_victim_addr_nxt;
        w_mem_wr_data_d = w_victim_data_nxt;
      end
      StWbWait: begin
        w_mem_addr_d    = w_victim_addr_nxt;
        w_mem_wr_data_d = w_victim_data_nxt;
      end
      StFillReq: begin
        w_mem_read_d = 1'b1;
        w_mem_addr_d = w_miss_addr_nxt;
      end
      StFillWait: begin
        w_mem_addr_d = w_miss_addr_nxt;
      end
      default: begin
        w_mem_read_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge m_clk_i or posedge m_reset_i) begin
    if (m_reset_i) begin
      r_state       <= StIdle;
      r_wait_cnt    <= '0;
      r_miss_addr   <= '0;
      r_victim_addr <= '0;
      r_victim_data <= '0;
      r_dirty       <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
      r_fill_data   <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_wait_cnt    <= w_wait_cnt_d;
      r_miss_addr   <= w_miss_addr_nxt;
      r_victim_addr <= w_victim_addr_nxt;
      r_victim_data <= w_victim_data_nxt;
      r_dirty       <= w_dirty_nxt;
      r_mem_read    <= w_mem_read_d;
      r_mem_wr      <= w_mem_wr_d;
      r_mem_addr    <= w_mem_addr_d;
      r_mem_wr_data <= w_mem_wr_data_d;
      if ((r_state == StFillWait) && mem_read_done_i) r_fill_data <= mem_read_data_i;
      // Sticky until reset.
      r_err         <= r_err | (w_state_d == StErr);
    end
  end

  assign c_busy_o       = (r_state != StIdle);
  assign c_fill_valid_o = (r_state == StResp);
  assign c_fill_data_o  = r_fill_data;
  assign c_err_o        = r_err;
  assign mem_read_o     = r_mem_read;
  assign mem_wr_o       = r_mem_wr;
  assign mem_addr_o     = r_mem_addr;
  assign mem_wr_data_o  = r_mem_wr_data;

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameters SHALL be: c_block_size, default 2, log2 of words per block; c_line_size, default 32, word width in bits; address_size, default 32, byte address width; c_timeout, default 64, maximum wait cycles per memory phase.
REQ-002 Derived widths SHALL be: BW = 2**c_block_size*c_line_size (128 at defaults); AW = address_size-c_block_size-2 (28 at defaults).
REQ-003 m_clk_i  in  1  clock; all state updates occur on the rising edge.
REQ-004 m_reset_i  in  1  asynchronous, active-high reset.
REQ-005 c_miss_i  in  1  cache miss request; sampled only in IDLE.
REQ-006 c_dirty_i  in  1  victim block dirty; sampled together with c_miss_i.
REQ-007 c_miss_addr_i  in  AW  block address to fill.
REQ-008 c_victim_addr_i  in  AW  block address for write-back.
REQ-009 c_victim_data_i  in  BW  block data for write-back.
REQ-010 c_busy_o  out  1  controller is not in IDLE.
REQ-011 c_fill_valid_o  out  1  one-cycle pulse; c_fill_data_o is valid.
REQ-012 c_fill_data_o  out  BW  block returned by memory.
REQ-013 c_err_o  out  1  sticky timeout flag.
REQ-014 mem_read_o, mem_wr_o  out  1 each  block read and block write requests to memory.
REQ-015 mem_addr_o  out  AW  block address; mem_wr_data_o  out  BW  write block.
REQ-016 mem_busywait_i, mem_read_done_i, mem_write_done_i  in  1 each  memory status inputs.
REQ-017 mem_read_data_i  in  BW  memory read block; valid in the cycle that mem_read_done_i is high.

Function
REQ-018 States SHALL be IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP, ERR.
REQ-019 In IDLE with c_miss_i=1, the controller SHALL latch the miss address, victim address, victim data and dirty bit, then go to WB_REQ if dirty and to FILL_REQ otherwise.
REQ-020 c_miss_i SHALL be ignored in every state except IDLE.
REQ-021 WB_REQ SHALL drive mem_wr_o=1, mem_addr_o=latched victim address and mem_wr_data_o=latched victim data.
REQ-022 WB_REQ SHALL advance to WB_WAIT on the first edge at which mem_busywait_i=1.
REQ-023 WB_WAIT SHALL drive mem_wr_o=0 while holding mem_addr_o and mem_wr_data_o stable.
REQ-024 WB_WAIT SHALL go to FILL_REQ on mem_write_done_i=1.
REQ-025 FILL_REQ SHALL drive mem_read_o=1 and mem_addr_o=latched miss address, and SHALL advance to FILL_WAIT on mem_busywait_i=1.
REQ-026 FILL_WAIT SHALL drive mem_read_o=0 with the address held.
REQ-027 On mem_read_done_i=1 in FILL_WAIT, the controller SHALL capture mem_read_data_i into c_fill_data_o and go to RESP.
REQ-028 RESP SHALL assert c_fill_valid_o for exactly one cycle and then return to IDLE.
REQ-029 c_fill_data_o SHALL hold its value until the next capture.
REQ-030 mem_read_o and mem_wr_o SHALL never be high in the same cycle.
REQ-031 Both SHALL be 0 in IDLE, RESP and ERR.
REQ-032 mem_read_done_i in a WB state and mem_write_done_i in a FILL state SHALL be ignored.
REQ-033 c_busy_o SHALL be 1 in every state except IDLE.
REQ-034 A wait counter (8 bits minimum) SHALL clear on every state change and increment each cycle spent in WB_REQ, WB_WAIT, FILL_REQ or FILL_WAIT.
REQ-035 When the wait counter reaches c_timeout-1 without a state change, the controller SHALL go to ERR.
REQ-036 ERR SHALL set c_err_o, issue no fill pulse, and return to IDLE after one cycle.
REQ-037 c_err_o SHALL clear only on reset.
REQ-038 Memory outputs SHALL come from registers only, with no combinational path from cache inputs.

Reset
REQ-039 Reset SHALL act asynchronously at any time, including mid-transaction, and SHALL force IDLE, the wait counter to 0, all latched registers to 0, and every output to 0.
REQ-040 After reset is released, the first request SHALL be accepted on the first edge at which c_miss_i=1.

Verification
REQ-041 The bench SHALL use a responder model with 4 busy cycles followed by a one-cycle done pulse, and SHALL cover these scenarios:
- Clean miss, miss addr 0x0000010, memory block 0x0123...CDEF -> one read with no write; c_fill_valid_o pulses once with the data; c_busy_o returns to 0.
- Dirty miss, victim 0x0000020 with data 0xAAAA..., miss 0x0000030 -> mem_wr_o precedes mem_read_o; memory at 0x20 is updated; the fill then completes.
- c_miss_i held high through a transaction -> exactly one transaction runs; a second one starts only after RESP.
- Responder never raises busywait, c_timeout=64 -> ERR after 64 cycles in FILL_REQ; c_err_o=1 stays set until reset.
- m_reset_i asserted during FILL_WAIT -> all outputs 0 immediately; a new miss after release completes normally.
- Spurious mem_read_done_i during WB_WAIT -> ignored; the controller waits for mem_write_done_i.
